fifo_16x8: RTL
==============

# fifo_16x8

Synchronous FIFO controller that acts as the initiator for a registered-output dual-port RAM. It owns the write and read pointers and drives the RAM's write-enable, read-enable and both addresses. It presents a push/pop interface to the surrounding datapath, with full, empty, occupancy and error flags. It sits between a producer stage and a consumer stage on the same clock and buffers up to DEPTH words.

## Interface
- WIDTH, 8, data word width
- DEPTH, 16, number of entries; power of two
- ADDR, 4, log2(DEPTH); RAM address width
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  push request
- wr_data  in  WIDTH  push data
- rd_en  in  1  pop request
- rd_data  out  WIDTH  popped word (registered)
- rd_valid  out  1  rd_data holds a newly popped word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- count  out  ADDR+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: wr_en while full
- underflow  out  1  one-cycle pulse: rd_en while empty

## Operation
- Pointers wr_ptr and rd_ptr are ADDR+1 bits wide. The low ADDR bits address the RAM; the MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = low bits equal and MSBs differ.
- count = wr_ptr − rd_ptr, modulo 2^(ADDR+1).
- Push accepted iff wr_en && !full, using flags sampled before the edge. On accept: RAM we=1, wr_addr=wr_ptr[ADDR-1:0], and wr_ptr increments.
- Pop accepted iff rd_en && !empty, using flags sampled before the edge. On accept: RAM re=1, rd_addr=rd_ptr[ADDR-1:0], and rd_ptr increments.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted; count unchanged.
  - Full: pop accepted, push rejected, overflow pulses. No write-through to a freed slot in the same cycle.
  - Empty: push accepted, pop rejected, underflow pulses. No fall-through; the word is poppable on the next cycle.
- Rejected requests never move pointers and never touch the RAM.
- Pointer wrap: after DEPTH accepted pushes, wr_ptr[ADDR-1:0] returns to 0 and wr_ptr[ADDR] toggles.
- rd_data holds its last value when no pop is accepted.
- RAM contents are not cleared by reset. Stale data is unreachable because pointers reset.

## Timing
- Reset (rst=1 at an edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
- Reset overrides any same-cycle wr_en or rd_en.
- Reset mid-operation discards all contents; the FIFO is empty on the following cycle.
- Push latency: data accepted at edge N is readable by a pop issued in cycle N+1.
- Pop latency: 1 cycle. For a pop accepted at edge N, rd_data and rd_valid=1 are valid after edge N+1. rd_valid is high for exactly one cycle per accepted pop.
- Back-to-back pops give rd_valid high on consecutive cycles.
- Flags: full, empty, almost_full and count are registered. They reflect all pushes and pops accepted up to and including the last edge.
- overflow and underflow are registered one-cycle pulses, asserted the cycle after the offending request.

## Structure
- Shared package holds:
  - WIDTH, DEPTH, ADDR defaults
  - pointer type (ADDR+1 bits)
  - count type (ADDR+1 bits)
- One sub-module, fifo_mem:
  - WIDTH×DEPTH dual-port RAM, synchronous write and registered read
  - ports: clk, rst, we, re, wr_addr, rd_addr, wr_data, d_out
- Controller logic (pointers, flags, pulses, rd_valid pipeline) lives in fifo_16x8.

## Test plan
- Reset then idle: all outputs at their reset values; count=0, empty=1.
- Push 0x01..0x10, then 16 pops:
  - full=1 after the 16th push; almost_full=1 from count=12.
  - rd_data sequence 0x01..0x10 with rd_valid high for 16 consecutive cycles; empty=1 at the end.
- Push 0xAA while full: overflow pulses once, count stays 16, and the next 16 pops never return 0xAA.
- Pop while empty: underflow pulses, rd_valid stays 0, rd_data is unchanged.
- Simultaneous push and pop:
  - Count=5: count stays 5, and data order is preserved across 40 cycles including pointer wrap.
  - Empty: push 0x3C accepted and underflow pulses; a pop on the next cycle returns 0x3C.
- Push 8 words, then assert rst mid-stream: next cycle empty=1, count=0, rd_valid=0. A following push of 0x55 and a pop return 0x55.

Source files
------------

// File: rtl/fifo_16x8_pkg.sv
// Shared parameters and types for the 16x8 synchronous FIFO controller and its RAM.
package fifo_16x8_pkg;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int ADDR     = 4;
    localparam int AF_LEVEL = 12;

    typedef logic [ADDR:0]    ptr_t;
    typedef logic [ADDR:0]    count_t;
    typedef logic [ADDR-1:0]  addr_t;
    typedef logic [WIDTH-1:0] data_t;

    localparam ptr_t PTR_ONE = {{ADDR{1'b0}}, 1'b1};

    // Full when the slot indices match but the wrap bits differ.
    function automatic logic ptr_full(input ptr_t wr_ptr, input ptr_t rd_ptr);
        return (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]) && (wr_ptr[ADDR] != rd_ptr[ADDR]);
    endfunction

endpackage

// File: rtl/fifo_16x8_if.sv
// Push/pop bus between the FIFO controller and its producer/consumer.
interface fifo_16x8_if;
    import fifo_16x8_pkg::*;

    logic   wr_en;
    data_t  wr_data;
    logic   rd_en;
    data_t  rd_data;
    logic   rd_valid;
    logic   full;
    logic   empty;
    logic   almost_full;
    count_t count;
    logic   overflow;
    logic   underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_16x8_mem.sv
// WIDTH x DEPTH dual-port RAM: synchronous write, registered read.
// Array contents are never reset; only the read register is.
module fifo_mem
    import fifo_16x8_pkg::*;
#(
    parameter int P_WIDTH = WIDTH,
    parameter int P_DEPTH = DEPTH,
    parameter int P_ADDR  = ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic               re,
    input  logic [P_ADDR-1:0]  wr_addr,
    input  logic [P_ADDR-1:0]  rd_addr,
    input  logic [P_WIDTH-1:0] wr_data,
    output logic [P_WIDTH-1:0] d_out
);

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [P_WIDTH-1:0] d_out_q;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read register; holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_q <= {P_WIDTH{1'b0}};
        end else if (re) begin
            d_out_q <= mem_q[rd_addr];
        end
    end

    assign d_out = d_out_q;

endmodule

// File: rtl/fifo_16x8.sv
// FIFO controller: owns the pointers, flags and error pulses, and drives the RAM
// command signals from registers, so a pop accepted at edge N shows data after N+1.
module fifo_16x8
    import fifo_16x8_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fifo_16x8_if.slave    bus
);

    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    count_t count_q, count_d;
    logic   full_q, empty_q, af_q;
    logic   overflow_q, underflow_q;
    logic   we_q, re_q, rd_valid_q;
    addr_t  wr_addr_q, rd_addr_q;
    data_t  wr_data_q;
    data_t  rd_data_s;
    logic   push_s, pop_s;

    // Acceptance uses the registered flags, then next-state pointers and occupancy.
    always_comb begin
        push_s = bus.wr_en && !full_q;
        pop_s  = bus.rd_en && !empty_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_t'(wr_ptr_d - rd_ptr_d);
    end

    // Pointers, flags, pulses and the registered RAM command stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= {(ADDR+1){1'b0}};
            rd_ptr_q    <= {(ADDR+1){1'b0}};
            count_q     <= {(ADDR+1){1'b0}};
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_addr_q   <= {ADDR{1'b0}};
            rd_addr_q   <= {ADDR{1'b0}};
            wr_data_q   <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= ptr_full(wr_ptr_d, rd_ptr_d);
            empty_q     <= (wr_ptr_d == rd_ptr_d);
            af_q        <= (count_d >= count_t'(AF_LEVEL));
            overflow_q  <= bus.wr_en && full_q;
            underflow_q <= bus.rd_en && empty_q;
            we_q        <= push_s;
            re_q        <= pop_s;
            rd_valid_q  <= re_q;
            wr_addr_q   <= wr_ptr_q[ADDR-1:0];
            rd_addr_q   <= rd_ptr_q[ADDR-1:0];
            wr_data_q   <= bus.wr_data;
        end
    end

    fifo_mem #(
        .P_WIDTH (WIDTH),
        .P_DEPTH (DEPTH),
        .P_ADDR  (ADDR)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (we_q),
        .re      (re_q),
        .wr_addr (wr_addr_q),
        .rd_addr (rd_addr_q),
        .wr_data (wr_data_q),
        .d_out   (rd_data_s)
    );

    assign bus.rd_data     = rd_data_s;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.almost_full = af_q;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule
